// File: rtl/mpe_pkg.sv
// Shared widths and line/mask types for the matrix_pe result path.
package mpe_pkg;

   localparam int DATA_W = 32;
   localparam int LANES  = 16;
   localparam int LINE_W = DATA_W * LANES;

   typedef logic [LINE_W-1:0] line_t;
   typedef logic [LANES-1:0]  mask_t;

   // FIFO entry: mask sits above the line so {mask, line} maps directly onto the outputs.
   typedef struct packed {
      mask_t mask;
      line_t line;
   } entry_t;

endpackage

// File: rtl/mpe_line_fifo.sv
// Line buffer between the packer and the NRAM writeback; a push is taken while full when a pop
// frees a slot on the same edge.
module mpe_line_fifo #(
   parameter int WIDTH = 528,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [PW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count == (PW+1)'(DEPTH));
   assign empty_o = (count == '0);
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);
   // Head is zeroed while empty so nothing stale shows on the output.
   assign rdata_o = empty_o ? '0 : mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) begin
            mem[wptr] <= wdata_i;
            wptr      <= wptr + 1'b1;
         end
         if (pop_ok) rptr <= rptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mpe_result_packer.sv
// Packs matrix_pe result words into LANES-wide lines (optional ReLU clamp) and queues the
// lines for the NRAM writeback.
module mpe_result_packer #(
   parameter int DATA_W     = mpe_pkg::DATA_W,
   parameter int LANES      = mpe_pkg::LANES,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       result_i,
   input  logic                    vld_i,
   input  logic                    relu_en_i,
   input  logic                    flush_i,
   output logic [DATA_W*LANES-1:0] line_o,
   output logic [LANES-1:0]        mask_o,
   output logic                    line_valid_o,
   input  logic                    line_ready_i,
   output logic [15:0]             line_cnt_o,
   output logic                    overflow_o
);

   import mpe_pkg::*;

   localparam int CW = $clog2(LANES);

   logic [CW-1:0] lane_cnt_p0;
   line_t         asm_line_p0;
   line_t         line_nxt;
   mask_t         mask_nxt;
   logic [CW:0]   fill;
   logic          push_req;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   entry_t        wr_entry;
   entry_t        rd_entry;

   function automatic logic [DATA_W-1:0] relu_clamp(input logic signed [DATA_W-1:0] v,
                                                    input logic en);
      return (en && v < 0) ? '0 : v;
   endfunction

   // Fill count includes a result arriving in the same cycle as a flush.
   always_comb begin
      line_nxt = asm_line_p0;
      for (int k = 0; k < LANES; k++) begin
         if (vld_i && 32'(lane_cnt_p0) == k)
            line_nxt[k*DATA_W +: DATA_W] = relu_clamp(result_i, relu_en_i);
      end
      fill = {1'b0, lane_cnt_p0} + (CW+1)'(vld_i);
      for (int k = 0; k < LANES; k++) mask_nxt[k] = (32'(fill) > k);
      push_req = (vld_i && lane_cnt_p0 == CW'(LANES-1)) || (flush_i && fill != '0);
   end

   // Stage 0: assembly register, cleared whenever a line leaves it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt_p0 <= '0;
         asm_line_p0 <= '0;
      end else if (push_req) begin
         lane_cnt_p0 <= '0;
         asm_line_p0 <= '0;
      end else begin
         asm_line_p0 <= line_nxt;
         if (vld_i) lane_cnt_p0 <= lane_cnt_p0 + 1'b1;
      end
   end

   assign wr_entry = {mask_nxt, line_nxt};
   assign pop      = !fifo_empty && line_ready_i;

   mpe_line_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_req),
      .wdata_i (wr_entry),
      .pop_i   (pop),
      .rdata_o (rd_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Stage 1: FIFO head drives the downstream handshake.
   assign line_valid_o     = !fifo_empty;
   assign {mask_o, line_o} = rd_entry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_cnt_o <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (pop) line_cnt_o <= line_cnt_o + 16'd1;
         if (push_req && fifo_full && !pop) overflow_o <= 1'b1;
      end
   end

endmodule
